// File: rtl/target_generator_if.sv
// Signal bundle between the game master / snake control and the target generator.
// The master modport is the game side; the slave modport is the generator itself.
interface target_generator_if;
    logic [1:0] MASTER_STATE;
    logic       REACHED_TARGET;
    logic [7:0] TARGET_X;
    logic [6:0] TARGET_Y;
    logic       TARGET_VALID;
    logic [3:0] SCORE;
    logic       WIN_PULSE;

    modport master (
        output MASTER_STATE,
        output REACHED_TARGET,
        input  TARGET_X,
        input  TARGET_Y,
        input  TARGET_VALID,
        input  SCORE,
        input  WIN_PULSE
    );

    modport slave (
        input  MASTER_STATE,
        input  REACHED_TARGET,
        output TARGET_X,
        output TARGET_Y,
        output TARGET_VALID,
        output SCORE,
        output WIN_PULSE
    );
endinterface

// File: rtl/target_generator.sv
// Snake game target placement and scoring: free-running LFSR pair supplies
// candidate coordinates, a small FSM tracks eat / re-pick / win.
module target_generator #(
    parameter int         MaxX     = 159,
    parameter int         MaxY     = 119,
    parameter int         WinScore = 10,
    parameter int         InitX    = 120,
    parameter int         InitY    = 30,
    parameter logic [7:0] SeedX    = 8'hA5,
    parameter logic [6:0] SeedY    = 7'h5A
) (
    input  logic              CLK,
    input  logic              RESET,
    target_generator_if.slave tg
);
    localparam logic [1:0] MS_IDLE    = 2'b00;
    localparam logic [1:0] MS_PLAY    = 2'b01;
    localparam logic [7:0] MAX_X_C    = 8'(MaxX);
    localparam logic [6:0] MAX_Y_C    = 7'(MaxY);
    localparam logic [3:0] WIN_C      = 4'(WinScore);
    localparam logic [7:0] INIT_X_C   = 8'(InitX);
    localparam logic [6:0] INIT_Y_C   = 7'(InitY);

    typedef enum logic [1:0] {ARMED, PICK, WON} state_t;

    state_t     state_reg, state_next;
    logic [7:0] lfsr_x_reg, lfsr_x_next;
    logic [6:0] lfsr_y_reg, lfsr_y_next;
    logic [7:0] target_x_reg, target_x_next;
    logic [6:0] target_y_reg, target_y_next;
    logic       valid_reg, valid_next;
    logic [3:0] score_reg, score_next;
    logic       win_pulse_reg, win_pulse_next;

    logic       eat;
    logic       accept;
    logic       last_target;

    // Fibonacci LFSRs: x^8+x^6+x^5+x^4+1 and x^7+x^6+1, both maximal length,
    // so a nonzero seed never reaches the all-zero lockup state.
    assign lfsr_x_next = {lfsr_x_reg[6:0], lfsr_x_reg[7] ^ lfsr_x_reg[5] ^ lfsr_x_reg[4] ^ lfsr_x_reg[3]};
    assign lfsr_y_next = {lfsr_y_reg[5:0], lfsr_y_reg[6] ^ lfsr_y_reg[5]};

    assign eat         = (tg.MASTER_STATE == MS_PLAY) && (state_reg == ARMED) && tg.REACHED_TARGET;
    assign last_target = (score_reg + 4'd1) == WIN_C;
    assign accept      = (tg.MASTER_STATE == MS_PLAY) && (state_reg == PICK)
                         && (lfsr_x_reg <= MAX_X_C) && (lfsr_y_reg <= MAX_Y_C)
                         && !((lfsr_x_reg == target_x_reg) && (lfsr_y_reg == target_y_reg));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg     <= ARMED;
            lfsr_x_reg    <= SeedX;
            lfsr_y_reg    <= SeedY;
            target_x_reg  <= INIT_X_C;
            target_y_reg  <= INIT_Y_C;
            valid_reg     <= 1'b1;
            score_reg     <= 4'd0;
            win_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lfsr_x_reg    <= lfsr_x_next;
            lfsr_y_reg    <= lfsr_y_next;
            target_x_reg  <= target_x_next;
            target_y_reg  <= target_y_next;
            valid_reg     <= valid_next;
            score_reg     <= score_next;
            win_pulse_reg <= win_pulse_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (tg.MASTER_STATE == MS_IDLE) begin
            state_next = ARMED;
        end else if (tg.MASTER_STATE == MS_PLAY) begin
            case (state_reg)
                ARMED:   if (eat) state_next = last_target ? WON : PICK;
                PICK:    if (accept) state_next = ARMED;
                WON:     state_next = WON;
                default: state_next = ARMED;
            endcase
        end
    end

    // WIN and the reserved master code fall through with everything held.
    always_comb begin
        target_x_next  = target_x_reg;
        target_y_next  = target_y_reg;
        valid_next     = valid_reg;
        score_next     = score_reg;
        win_pulse_next = 1'b0;
        if (tg.MASTER_STATE == MS_IDLE) begin
            target_x_next = INIT_X_C;
            target_y_next = INIT_Y_C;
            valid_next    = 1'b1;
            score_next    = 4'd0;
        end else if (eat) begin
            score_next     = score_reg + 4'd1;
            valid_next     = 1'b0;
            win_pulse_next = last_target;
        end else if (accept) begin
            target_x_next = lfsr_x_reg;
            target_y_next = lfsr_y_reg;
            valid_next    = 1'b1;
        end
    end

    assign tg.TARGET_X     = target_x_reg;
    assign tg.TARGET_Y     = target_y_reg;
    assign tg.TARGET_VALID = valid_reg;
    assign tg.SCORE        = score_reg;
    assign tg.WIN_PULSE    = win_pulse_reg;
endmodule

// File: doc/target_generator.md
TARGET_GENERATOR -- requirements
Module: target_generator

Interface
REQ-001 Parameter MaxX, default 159, largest legal target X (160 columns).
REQ-002 Parameter MaxY, default 119, largest legal target Y (120 rows).
REQ-003 Parameter WinScore, default 10, range 1..15, targets eaten to win.
REQ-004 Parameter InitX / InitY, default 120 / 30, first target after reset or IDLE.
REQ-005 Parameter SeedX / SeedY, default 8'hA5 / 7'h5A, LFSR reset values; both SHALL be nonzero.
REQ-006 CLK  input  1  system clock; all state changes on rising edge.
REQ-007 RESET  input  1  asynchronous, active-low reset (0 = reset).
REQ-008 MASTER_STATE  input  2  game state: 00 IDLE, 01 PLAY, 10 WIN.
REQ-009 REACHED_TARGET  input  1  one-cycle pulse from snake control when head hits target.
REQ-010 TARGET_X  output  8  current target column, always <= MaxX.
REQ-011 TARGET_Y  output  7  current target row, always <= MaxY.
REQ-012 TARGET_VALID  output  1  high when TARGET_X/Y is a live target.
REQ-013 SCORE  output  4  targets eaten in current game.
REQ-014 WIN_PULSE  output  1  one-cycle pulse to master state machine when SCORE reaches WinScore.

Function
REQ-015 An 8-bit Fibonacci LFSR (taps 8,6,5,4) and a 7-bit LFSR (taps 7,6) SHALL advance every CLK cycle regardless of state; neither SHALL ever hold zero.
REQ-016 FSM states: ARMED, PICK, WON; registered outputs only.
REQ-017 ARMED: TARGET_VALID=1; on REACHED_TARGET=1 with MASTER_STATE=PLAY, SCORE <= SCORE+1 and next state = WON if SCORE+1 == WinScore, else PICK.
REQ-018 PICK: TARGET_VALID=0; each cycle the candidate (lfsr_x, lfsr_y) SHALL be accepted only if lfsr_x <= MaxX, lfsr_y <= MaxY and candidate != current TARGET; otherwise retry next cycle.
REQ-019 On acceptance TARGET_X/Y SHALL load the candidate, TARGET_VALID SHALL rise and state SHALL return to ARMED, all on the same edge.
REQ-020 Latency: REACHED_TARGET sampled at edge N gives SCORE updated and TARGET_VALID=0 after edge N; earliest new target after edge N+1.
REQ-021 WON: WIN_PULSE=1 for exactly the first cycle after entry, TARGET_VALID=0, SCORE held at WinScore; stay until MASTER_STATE=IDLE.
REQ-022 REACHED_TARGET SHALL be ignored in PICK, in WON, and whenever MASTER_STATE != PLAY.
REQ-023 MASTER_STATE=IDLE, any state: synchronously SCORE<=0, TARGET<=(InitX,InitY), TARGET_VALID<=1, WIN_PULSE<=0, state<=ARMED; LFSRs keep running.
REQ-024 MASTER_STATE=WIN or a reserved code (11) SHALL freeze FSM, SCORE and TARGET; LFSRs keep running.
REQ-025 SCORE SHALL never exceed WinScore and SHALL never wrap.

Reset
REQ-026 RESET=0 SHALL immediately force: state ARMED, TARGET_X=InitX, TARGET_Y=InitY, TARGET_VALID=1, SCORE=0, WIN_PULSE=0, LFSRs=SeedX/SeedY.
REQ-027 Reset asserted in PICK or WON SHALL abort the operation with no WIN_PULSE or partial target load.
REQ-028 After RESET deasserts, the first state change SHALL occur no earlier than the next rising CLK edge.

Verification
REQ-029 Reset release, MASTER_STATE=PLAY, no pulse for 100 cycles -> TARGET=(120,30), VALID=1, SCORE=0 throughout.
REQ-030 One REACHED_TARGET pulse in PLAY -> SCORE=1, VALID low >= 1 cycle, new target != (120,30), X<=159, Y<=119; reference-model LFSR predicts exact value and cycle.
REQ-031 10 pulses, each after VALID high -> SCORE=10, single WIN_PULSE cycle, VALID=0 held; 11th pulse ignored, SCORE stays 10.
REQ-032 Pulse while in PICK, and pulse with MASTER_STATE=IDLE -> SCORE unchanged by the ignored pulse.
REQ-033 From WON, MASTER_STATE=IDLE one cycle -> SCORE=0, TARGET=(120,30), VALID=1, state ARMED.
REQ-034 RESET=0 asserted mid-PICK between clock edges -> outputs at reset values before next edge; 10,000 random pulses never produce out-of-range target.
